// File: rtl/calc_port_scheduler.sv
// Four-port front end for one shared calc ALU slice: per-port two-cycle request
// capture, invalid-command screening, round-robin issue and response routing.

module calc_port_fsm #(
  parameter int DATA_W = 32
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [0:3]        cmd_in,
  input  logic [0:DATA_W-1] data_in,
  input  logic              cpl_vld,
  input  logic [0:1]        cpl_resp,
  input  logic [0:DATA_W-1] cpl_data,
  output logic              pend,
  output logic [0:3]        cmd,
  output logic [0:DATA_W-1] op1,
  output logic [0:DATA_W-1] op2,
  output logic [0:1]        resp,
  output logic [0:DATA_W-1] data
);
  typedef enum logic [1:0] {P_IDLE, P_OP2, P_PEND} pst_e;

  pst_e              st_q, st_d;
  logic [0:3]        cmd_q, cmd_d;
  logic [0:DATA_W-1] op1_q, op1_d, op2_q, op2_d, data_q, data_d;
  logic [0:1]        resp_q, resp_d;
  logic              cmd_ok;

  assign cmd_ok = (cmd_q == 4'd1) || (cmd_q == 4'd2) || (cmd_q == 4'd5) || (cmd_q == 4'd6);

  always_comb begin
    st_d   = st_q;
    cmd_d  = cmd_q;
    op1_d  = op1_q;
    op2_d  = op2_q;
    resp_d = 2'd0;
    data_d = '0;
    case (st_q)
      // a port is deaf during its own response cycle
      P_IDLE: if (cmd_in != 4'd0 && resp_q == 2'd0) begin
        st_d  = P_OP2;
        cmd_d = cmd_in;
        op1_d = data_in;
      end
      P_OP2: begin
        op2_d = data_in;
        if (cmd_ok) st_d = P_PEND;
        else begin
          st_d   = P_IDLE;
          resp_d = 2'd2;
        end
      end
      P_PEND: if (cpl_vld) begin
        st_d   = P_IDLE;
        resp_d = cpl_resp;
        data_d = cpl_data;
      end
      default: st_d = P_IDLE;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      st_q   <= P_IDLE;
      cmd_q  <= '0;
      op1_q  <= '0;
      op2_q  <= '0;
      resp_q <= '0;
      data_q <= '0;
    end else begin
      st_q   <= st_d;
      cmd_q  <= cmd_d;
      op1_q  <= op1_d;
      op2_q  <= op2_d;
      resp_q <= resp_d;
      data_q <= data_d;
    end
  end

  assign pend = (st_q == P_PEND);
  assign cmd  = cmd_q;
  assign op1  = op1_q;
  assign op2  = op2_q;
  assign resp = resp_q;
  assign data = data_q;
endmodule

module calc_port_scheduler #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [0:3]        req1_cmd_in,
  input  logic [0:3]        req2_cmd_in,
  input  logic [0:3]        req3_cmd_in,
  input  logic [0:3]        req4_cmd_in,
  input  logic [0:DATA_W-1] req1_data_in,
  input  logic [0:DATA_W-1] req2_data_in,
  input  logic [0:DATA_W-1] req3_data_in,
  input  logic [0:DATA_W-1] req4_data_in,
  output logic [0:1]        out_resp1,
  output logic [0:1]        out_resp2,
  output logic [0:1]        out_resp3,
  output logic [0:1]        out_resp4,
  output logic [0:DATA_W-1] out_data1,
  output logic [0:DATA_W-1] out_data2,
  output logic [0:DATA_W-1] out_data3,
  output logic [0:DATA_W-1] out_data4,
  output logic              alu_valid,
  output logic [0:3]        alu_cmd,
  output logic [0:DATA_W-1] alu_op1,
  output logic [0:DATA_W-1] alu_op2,
  input  logic              alu_done,
  input  logic [0:1]        alu_resp,
  input  logic [0:DATA_W-1] alu_data,
  output logic [0:1]        alu_port
);
  localparam int NUM_PORTS = 4;
  localparam int CNT_W     = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {A_IDLE, A_ISSUE, A_WAIT} ast_e;

  logic [NUM_PORTS-1:0][0:3]        p_cmd_in, p_cmd;
  logic [NUM_PORTS-1:0][0:DATA_W-1] p_din, p_op1, p_op2, p_data;
  logic [NUM_PORTS-1:0][0:1]        p_resp;
  logic [NUM_PORTS-1:0]             p_pend, cpl_vld;
  logic [0:1]                       cpl_resp;
  logic [0:DATA_W-1]                cpl_data;

  assign p_cmd_in = {req4_cmd_in, req3_cmd_in, req2_cmd_in, req1_cmd_in};
  assign p_din    = {req4_data_in, req3_data_in, req2_data_in, req1_data_in};

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    calc_port_fsm #(.DATA_W(DATA_W)) u_port (
      .c_clk    (c_clk),
      .reset    (reset),
      .cmd_in   (p_cmd_in[i]),
      .data_in  (p_din[i]),
      .cpl_vld  (cpl_vld[i]),
      .cpl_resp (cpl_resp),
      .cpl_data (cpl_data),
      .pend     (p_pend[i]),
      .cmd      (p_cmd[i]),
      .op1      (p_op1[i]),
      .op2      (p_op2[i]),
      .resp     (p_resp[i]),
      .data     (p_data[i])
    );
  end

  ast_e              ast_q, ast_d;
  logic [1:0]        ptr_q, ptr_d, gnt_q, gnt_d, alu_port_q, alu_port_d, sel;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              alu_valid_q, alu_valid_d, found;
  logic [0:3]        alu_cmd_q, alu_cmd_d;
  logic [0:DATA_W-1] alu_op1_q, alu_op1_d, alu_op2_q, alu_op2_d;

  always_comb begin
    ast_d       = ast_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    alu_valid_d = 1'b0;
    alu_cmd_d   = '0;
    alu_op1_d   = '0;
    alu_op2_d   = '0;
    alu_port_d  = alu_port_q;
    cpl_vld     = '0;
    cpl_resp    = 2'd0;
    cpl_data    = '0;
    found       = 1'b0;
    sel         = ptr_q;
    // search starts just after the last granted port; k=4 wraps back onto it
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!found && p_pend[2'(ptr_q + 2'(k))]) begin
        found = 1'b1;
        sel   = 2'(ptr_q + 2'(k));
      end
    end
    case (ast_q)
      A_IDLE: if (found) begin
        ast_d       = A_ISSUE;
        ptr_d       = sel;
        gnt_d       = sel;
        alu_valid_d = 1'b1;
        alu_cmd_d   = p_cmd[sel];
        alu_op1_d   = p_op1[sel];
        alu_op2_d   = p_op2[sel];
        alu_port_d  = sel;
      end
      A_ISSUE: begin
        ast_d = A_WAIT;
        cnt_d = CNT_W'(1);
      end
      A_WAIT: begin
        if (alu_done) begin
          ast_d          = A_IDLE;
          cpl_vld[gnt_q] = 1'b1;
          cpl_resp       = alu_resp;
          cpl_data       = (alu_resp == 2'd1) ? alu_data : '0;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          ast_d          = A_IDLE;
          cpl_vld[gnt_q] = 1'b1;
          cpl_resp       = 2'd2;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ast_d = A_IDLE;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      ast_q       <= A_IDLE;
      ptr_q       <= 2'd3;
      gnt_q       <= 2'd0;
      cnt_q       <= '0;
      alu_valid_q <= 1'b0;
      alu_cmd_q   <= '0;
      alu_op1_q   <= '0;
      alu_op2_q   <= '0;
      alu_port_q  <= 2'd0;
    end else begin
      ast_q       <= ast_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      alu_valid_q <= alu_valid_d;
      alu_cmd_q   <= alu_cmd_d;
      alu_op1_q   <= alu_op1_d;
      alu_op2_q   <= alu_op2_d;
      alu_port_q  <= alu_port_d;
    end
  end

  assign alu_valid = alu_valid_q;
  assign alu_cmd   = alu_cmd_q;
  assign alu_op1   = alu_op1_q;
  assign alu_op2   = alu_op2_q;
  assign alu_port  = alu_port_q;

  assign out_resp1 = p_resp[0];
  assign out_resp2 = p_resp[1];
  assign out_resp3 = p_resp[2];
  assign out_resp4 = p_resp[3];
  assign out_data1 = p_data[0];
  assign out_data2 = p_data[1];
  assign out_data3 = p_data[2];
  assign out_data4 = p_data[3];
endmodule

// File: tb/tb_calc_port_scheduler.sv
// Directed plus randomized checks of the four-port ALU scheduler against a
// request-level model: expected responses, grant order and latencies.

module tb_calc_port_scheduler;
  localparam int TO = 64;

  logic             c_clk = 1'b0;
  logic             reset = 1'b0;
  logic [3:0][3:0]  req_cmd;
  logic [3:0][31:0] req_dat;
  logic [3:0][1:0]  o_resp;
  logic [3:0][31:0] o_data;
  logic             alu_valid, alu_done;
  logic [3:0]       alu_cmd;
  logic [31:0]      alu_op1, alu_op2, alu_data;
  logic [1:0]       alu_resp, alu_port;

  calc_port_scheduler #(.DATA_W(32), .TIMEOUT(TO)) dut (
    .c_clk(c_clk), .reset(reset),
    .req1_cmd_in(req_cmd[0]), .req2_cmd_in(req_cmd[1]),
    .req3_cmd_in(req_cmd[2]), .req4_cmd_in(req_cmd[3]),
    .req1_data_in(req_dat[0]), .req2_data_in(req_dat[1]),
    .req3_data_in(req_dat[2]), .req4_data_in(req_dat[3]),
    .out_resp1(o_resp[0]), .out_resp2(o_resp[1]), .out_resp3(o_resp[2]), .out_resp4(o_resp[3]),
    .out_data1(o_data[0]), .out_data2(o_data[1]), .out_data3(o_data[2]), .out_data4(o_data[3]),
    .alu_valid(alu_valid), .alu_cmd(alu_cmd), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_done(alu_done), .alu_resp(alu_resp), .alu_data(alu_data), .alu_port(alu_port)
  );

  always #5 c_clk = ~c_clk;

  int n_chk = 0, n_fail = 0, cyc = 0;

  typedef struct { int cyc; int port; logic [1:0] resp; logic [31:0] data; } rsp_t;
  typedef struct { int cyc; int port; logic [3:0] cmd; logic [31:0] op1, op2; } iss_t;
  rsp_t rq[$];
  iss_t iq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference ALU behaviour: what a calc slice returns for a command
  function automatic logic [33:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    case (c)
      4'd1: begin s = {1'b0, a} + {1'b0, b}; return {(s[32] ? 2'd2 : 2'd1), s[31:0]}; end
      4'd2: return {(b > a ? 2'd2 : 2'd1), a - b};
      4'd5: return {2'd1, a << b[4:0]};
      4'd6: return {2'd1, a >> b[4:0]};
      default: return {2'd2, 32'd0};
    endcase
  endfunction

  // monitor: records responses and issues, checks idle-time zeroing
  initial forever begin
    @(posedge c_clk);
    cyc++;
    #1;
    for (int p = 0; p < 4; p++) begin
      if (o_resp[p] != 2'd0) rq.push_back('{cyc, p, o_resp[p], o_data[p]});
      if (o_resp[p] != 2'd1) chk("data_idle", o_data[p], 0);
    end
    if (alu_valid) iq.push_back('{cyc, int'(alu_port), alu_cmd, alu_op1, alu_op2});
    else chk("ops_idle", {alu_op1, alu_op2}, 0);
  end

  // ALU model: answers alu_lat cycles after the issue strobe
  int         alu_lat = 1, wait_c = 0;
  bit         alu_en = 1, busy = 0, force_done = 0;
  logic [3:0] cmd_l;
  logic [31:0] op1_l, op2_l;
  initial begin
    alu_done = 0; alu_resp = 0; alu_data = 0;
    forever begin
      @(posedge c_clk);
      #1;
      alu_done = 0; alu_resp = 0; alu_data = 0;
      if (busy) begin
        wait_c++;
        if (wait_c == alu_lat && alu_en) begin
          {alu_resp, alu_data} = alu_fn(cmd_l, op1_l, op2_l);
          alu_done = 1;
          busy = 0;
        end
      end
      if (force_done) begin alu_done = 1; alu_resp = 2'd1; alu_data = 32'h1234; end
      if (alu_valid) begin busy = 1; wait_c = 0; cmd_l = alu_cmd; op1_l = alu_op1; op2_l = alu_op2; end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge c_clk); #2; end
  endtask

  task automatic send(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req_cmd[p] = c; req_dat[p] = a;
    tick(1);
    req_cmd[p] = 0; req_dat[p] = b;
    tick(1);
    req_dat[p] = 0;
  endtask

  task automatic wait_rsp(input string tag, input int n, input int budget);
    int k = 0;
    while (rq.size() < n && k < budget) begin tick(1); k++; end
    chk({tag, "_wait"}, rq.size() >= n, 1);
  endtask

  task automatic pop_rsp(input string tag, input int p, input logic [1:0] er, input logic [31:0] ed, input int ec);
    int idx = -1;
    for (int i = 0; i < rq.size(); i++) if (idx < 0 && rq[i].port == p) idx = i;
    chk({tag, "_present"}, idx >= 0, 1);
    if (idx >= 0) begin
      chk({tag, "_resp"}, rq[idx].resp, er);
      chk({tag, "_data"}, rq[idx].data, ed);
      if (ec >= 0) chk({tag, "_cyc"}, rq[idx].cyc, ec);
      rq.delete(idx);
    end
  endtask

  task automatic pop_iss(input string tag, input int p, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input int ec);
    iss_t e;
    chk({tag, "_present"}, iq.size() > 0, 1);
    if (iq.size() > 0) begin
      e = iq.pop_front();
      chk({tag, "_port"}, e.port, p);
      chk({tag, "_cmd"}, e.cmd, c);
      chk({tag, "_ops"}, {e.op1, e.op2}, {a, b});
      if (ec >= 0) chk({tag, "_cyc"}, e.cyc, ec);
    end
  endtask

  task automatic drained(input string tag);
    chk({tag, "_extra_rsp"}, rq.size(), 0);
    chk({tag, "_extra_iss"}, iq.size(), 0);
  endtask

  logic [3:0] vcmd [4]  = '{4'd1, 4'd2, 4'd5, 4'd6};
  logic [3:0] icmd [11] = '{4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};

  initial begin
    int t, v, r, rr_ptr, nreq;
    logic [3:0]  rc [4];
    logic [31:0] ra [4], rb [4];
    logic [33:0] ex;
    int order [$];

    req_cmd = '0; req_dat = '0;
    tick(3);
    chk("rst_resp", o_resp, 0);
    chk("rst_data", o_data, 0);
    chk("rst_alu", {alu_valid, alu_cmd, alu_op1, alu_op2, alu_port}, 0);
    reset = 1;
    tick(2);

    // basic add, ALU latency 2
    alu_lat = 2; t = cyc;
    send(0, 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF);
    wait_rsp("t1", 1, 20); tick(3);
    pop_iss("t1_iss", 0, 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, t + 3);
    pop_rsp("t1_rsp", 0, 2'd1, 32'h3FFF_FFFE, t + 6);
    drained("t1");

    // invalid command, then an immediate valid one on the same port
    alu_lat = 1; t = cyc;
    send(1, 4'd3, 32'd1, 32'd0);
    tick(1);
    send(1, 4'd1, 32'd5, 32'd6);
    wait_rsp("t2", 2, 20); tick(3);
    pop_rsp("t2_inv", 1, 2'd2, 0, t + 2);
    pop_iss("t2_iss", 1, 4'd1, 32'd5, 32'd6, t + 6);
    pop_rsp("t2_ok", 1, 2'd1, 32'd11, t + 8);
    drained("t2");

    // all four at once from a fresh pointer, then ports 1 and 3 together
    reset = 0; tick(1); reset = 1; tick(1);
    for (int p = 0; p < 4; p++) begin req_cmd[p] = 4'd1; req_dat[p] = p + 1; end
    tick(1);
    for (int p = 0; p < 4; p++) begin req_cmd[p] = 0; req_dat[p] = 1; end
    tick(1); req_dat = '0;
    wait_rsp("t3", 4, 60); tick(3);
    for (int p = 0; p < 4; p++) pop_iss("t3_iss", p, 4'd1, p + 1, 1, -1);
    for (int p = 0; p < 4; p++) pop_rsp("t3_rsp", p, 2'd1, p + 2, -1);
    drained("t3a");
    req_cmd[0] = 4'd1; req_cmd[2] = 4'd1; req_dat[0] = 10; req_dat[2] = 30;
    tick(1);
    req_cmd = '0; req_dat[0] = 1; req_dat[2] = 3;
    tick(1); req_dat = '0;
    wait_rsp("t3b", 2, 40); tick(3);
    pop_iss("t3_rr0", 0, 4'd1, 10, 1, -1);
    pop_iss("t3_rr2", 2, 4'd1, 30, 3, -1);
    pop_rsp("t3_r0", 0, 2'd1, 11, -1);
    pop_rsp("t3_r2", 2, 2'd1, 33, -1);
    drained("t3b");

    // ALU never answers: timeout, then a late done is ignored
    alu_en = 0;
    send(0, 4'd1, 32'd7, 32'd8);
    wait_rsp("t4", 1, TO + 20);
    v = (iq.size() > 0) ? iq[0].cyc : -1;
    pop_iss("t4_iss", 0, 4'd1, 32'd7, 32'd8, -1);
    pop_rsp("t4_to", 0, 2'd2, 0, v + 1 + TO);
    tick(4); force_done = 1; tick(1); force_done = 0;
    tick(10);
    drained("t4");
    alu_en = 1;

    // underflow response; a second command while pending is dropped
    alu_lat = 2; t = cyc;
    send(0, 4'd2, 32'd0, 32'd1);
    req_cmd[0] = 4'd1; req_dat[0] = 9;
    tick(2);
    req_cmd[0] = 0; req_dat[0] = 0;
    tick(10);
    pop_iss("t5_iss", 0, 4'd2, 0, 1, t + 3);
    pop_rsp("t5_rsp", 0, 2'd2, 0, t + 6);
    drained("t5");

    // asynchronous reset during A_WAIT
    alu_lat = 10; t = cyc;
    send(1, 4'd1, 32'd3, 32'd4);
    tick(2);
    send(2, 4'd7, 32'd0, 32'd0);
    #1 reset = 0;
    #1;
    chk("t6_async_resp3", o_resp[2], 0);
    chk("t6_async_port", alu_port, 0);
    chk("t6_async_all", {o_resp, o_data, alu_valid, alu_cmd, alu_op1, alu_op2}, 0);
    pop_rsp("t6_inv", 2, 2'd2, 0, t + 6);
    pop_iss("t6_iss", 1, 4'd1, 3, 4, t + 3);
    tick(2); reset = 1;
    tick(15);
    drained("t6_late");
    alu_lat = 1; t = cyc;
    send(0, 4'd1, 32'd100, 32'd200);
    wait_rsp("t6b", 1, 20); tick(2);
    pop_iss("t6b_iss", 0, 4'd1, 100, 200, t + 3);
    pop_rsp("t6b_rsp", 0, 2'd1, 300, t + 5);
    drained("t6b");

    // randomized rounds against the request-level model
    rr_ptr = 0;
    for (int rnd = 0; rnd < 40; rnd++) begin
      r = $urandom_range(1, 15);
      alu_lat = $urandom_range(1, 4);
      nreq = 0;
      order.delete();
      for (int p = 0; p < 4; p++) begin
        rc[p] = 0;
        if (r[p]) begin
          rc[p] = ($urandom_range(0, 9) < 7) ? vcmd[$urandom_range(0, 3)] : icmd[$urandom_range(0, 10)];
          ra[p] = $urandom;
          rb[p] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
          nreq++;
        end
      end
      for (int k = 1; k <= 4; k++) begin
        v = (rr_ptr + k) % 4;
        if (r[v] && alu_fn(rc[v], 0, 0) != {2'd2, 32'd0} || (r[v] && rc[v] == 4'd2)) order.push_back(v);
      end
      t = cyc;
      for (int p = 0; p < 4; p++) begin req_cmd[p] = rc[p]; req_dat[p] = ra[p]; end
      tick(1);
      for (int p = 0; p < 4; p++) begin req_cmd[p] = 0; req_dat[p] = rb[p]; end
      tick(1); req_dat = '0;
      wait_rsp("rnd", nreq, 80); tick(3);
      foreach (order[i]) begin
        v = order[i];
        pop_iss("rnd_iss", v, rc[v], ra[v], rb[v], -1);
        ex = alu_fn(rc[v], ra[v], rb[v]);
        pop_rsp("rnd_rsp", v, ex[33:32], (ex[33:32] == 2'd1) ? ex[31:0] : 32'd0, -1);
        rr_ptr = v;
      end
      for (int p = 0; p < 4; p++)
        if (r[p] && !(rc[p] inside {4'd1, 4'd2, 4'd5, 4'd6})) pop_rsp("rnd_inv", p, 2'd2, 0, t + 2);
      drained("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
